imuldiv_ctrl: RTL

//  Sequencer for the iterative integer multiply/divide unit and owner of the HI/LO registers.

---
 rtl/imuldiv_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imuldiv_ctrl.sv
// rtl/imuldiv_ctrl.sv - iterative multiply/divide sequencer owning the HI/LO registers
module imuldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [3:0]            i_op,
  input  logic                  i_drop,
  input  logic [DATA_WIDTH-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_rt,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    hi_q, lo_q;
  // a_q: multiplicand for MUL, divisor for DIV
  logic [W-1:0]    a_q;
  // acc_q: {upper product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    rs_raw_q;
  logic            is_div_q, neg_q, dsign_q, dz_q;

  logic            hilo_op, req, accept, signed_op;
  logic [W-1:0]    mag_rs, mag_rt;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_acc_d, mul_fix_d;
  logic [W:0]      div_shift, div_diff;
  logic            div_qbit;
  logic [W-1:0]    div_rem;
  logic [2*W-1:0]  div_acc_d;
  logic [W-1:0]    div_q_fix, div_r_fix;

  // Issue decode, operand magnitudes and one-bit iteration datapaths
  always_comb begin
    hilo_op   = (i_op >= OP_MULT) && (i_op <= OP_MFLO);
    req       = i_valid && !i_drop && hilo_op;
    o_busy    = (state_q != S_IDLE);
    accept    = req && !o_busy;
    o_stall   = req && o_busy;
    o_result  = (i_op == OP_MFHI) ? hi_q : (i_op == OP_MFLO) ? lo_q : '0;
    signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    mag_rs    = (signed_op && i_rs[W-1]) ? -i_rs : i_rs;
    mag_rt    = (signed_op && i_rt[W-1]) ? -i_rt : i_rt;

    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_acc_d = {mul_sum, acc_q[W-1:1]};
    mul_fix_d = neg_q ? -acc_q : acc_q;

    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, a_q};
    div_qbit  = !div_diff[W];
    div_rem   = div_qbit ? div_diff[W-1:0] : div_shift[W-1:0];
    div_acc_d = {div_rem, acc_q[W-2:0], div_qbit};
    div_q_fix = neg_q   ? -acc_q[W-1:0]   : acc_q[W-1:0];
    div_r_fix = dsign_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  // Sequencer FSM and HI/LO ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      rs_raw_q <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dsign_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                state_q  <= S_MUL;
                is_div_q <= 1'b0;
                a_q      <= mag_rs;
                acc_q    <= {{W{1'b0}}, mag_rt};
              end
              OP_DIV, OP_DIVU: begin
                state_q  <= S_DIV;
                is_div_q <= 1'b1;
                a_q      <= mag_rt;
                acc_q    <= {{W{1'b0}}, mag_rs};
              end
              OP_MTHI: hi_q <= i_rs;
              OP_MTLO: lo_q <= i_rs;
              default: ;
            endcase
            cnt_q    <= CW'(W - 1);
            rs_raw_q <= i_rs;
            neg_q    <= signed_op && (i_rs[W-1] ^ i_rt[W-1]);
            dsign_q  <= signed_op && i_rs[W-1];
            dz_q     <= (i_rt == '0);
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          if (cnt_q == '0) state_q <= S_FIX;
          else cnt_q <= cnt_q - 1'b1;
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          if (cnt_q == '0) state_q <= S_FIX;
          else cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!is_div_q) begin
            {hi_q, lo_q} <= mul_fix_d;
          end else if (dz_q) begin
            lo_q <= '1;
            hi_q <= rs_raw_q;
          end else begin
            lo_q <= div_q_fix;
            hi_q <= div_r_fix;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
